// File: rtl/ddcpu_pkg.sv
`default_nettype none
// ============================================================================
// ddcpu_pkg : shared widths, option codes, field helpers for the dispatcher
// Revision  : 1.0
// ============================================================================
package ddcpu_pkg;

  localparam int WORKER_RESULT_WIDTH  = 67;
  localparam int PACKET_REQUEST_WIDTH = 99;

  typedef logic [2:0]                      dest_option_t;
  typedef logic [WORKER_RESULT_WIDTH-1:0]  worker_result_t;
  typedef logic [PACKET_REQUEST_WIDTH-1:0] packet_request_t;

  localparam dest_option_t OPT_NOP   = 3'd0;
  localparam dest_option_t OPT_END   = 3'd1;
  localparam dest_option_t OPT_EXEC  = 3'd2;
  localparam dest_option_t OPT_ONE   = 3'd3;
  localparam dest_option_t OPT_LEFT  = 3'd4;
  localparam dest_option_t OPT_RIGHT = 3'd5;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_PR   = 2'd1,
    TGT_MU   = 2'd2
  } target_e;

  function automatic dest_option_t wr_option(input worker_result_t w);
    return w[66:64];
  endfunction

  function automatic logic [15:0] wr_dest_addr(input worker_result_t w);
    return w[63:48];
  endfunction

  function automatic logic [15:0] wr_color(input worker_result_t w);
    return w[47:32];
  endfunction

  function automatic logic [31:0] wr_data(input worker_result_t w);
    return w[31:0];
  endfunction

  function automatic worker_result_t make_worker_result(
    input dest_option_t opt, input logic [15:0] addr,
    input logic [15:0] color, input logic [31:0] data);
    return {opt, addr, color, data};
  endfunction

  function automatic packet_request_t make_packet_request(
    input dest_option_t opt, input logic [15:0] addr,
    input logic [15:0] color, input logic [31:0] data, input logic [31:0] extra);
    return {opt, addr, color, data, extra};
  endfunction

  // Codes 6 and 7 fall into the default branch and behave as NOP.
  function automatic target_e wr_target(input worker_result_t w);
    case (wr_option(w))
      OPT_EXEC, OPT_ONE:  return TGT_PR;
      OPT_LEFT, OPT_RIGHT: return TGT_MU;
      default:            return TGT_NONE;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatcher_multi_if.sv
`default_nettype none
// ============================================================================
// dispatcher_multi_if : worker-result input lanes, MU lanes and PR port bundle
// Revision            : 1.0
// ============================================================================
interface dispatcher_multi_if #(
  parameter int NUM_IN = 2,
  parameter int NUM_MU = 2
);
  import ddcpu_pkg::*;

  logic [NUM_IN-1:0]                        RECEIVE_WR_VALID;
  logic [NUM_IN*WORKER_RESULT_WIDTH-1:0]    RECEIVE_WR_DATA;
  logic [NUM_IN-1:0]                        RECEIVE_WR_READY;
  logic [NUM_MU-1:0]                        SEND_WR_VALID;
  logic [NUM_MU*WORKER_RESULT_WIDTH-1:0]    SEND_WR_DATA;
  logic [NUM_MU-1:0]                        SEND_WR_READY;
  logic                                     SEND_PR_VALID;
  logic [PACKET_REQUEST_WIDTH-1:0]          SEND_PR_DATA;
  logic                                     SEND_PR_READY;
  logic                                     EXECUTION_END;

  // Environment side: workers and downstream consumers.
  modport master (
    output RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_WR_READY, SEND_PR_READY,
    input  RECEIVE_WR_READY, SEND_WR_VALID, SEND_WR_DATA,
    input  SEND_PR_VALID, SEND_PR_DATA, EXECUTION_END
  );

  // Dispatcher side.
  modport slave (
    input  RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_WR_READY, SEND_PR_READY,
    output RECEIVE_WR_READY, SEND_WR_VALID, SEND_WR_DATA,
    output SEND_PR_VALID, SEND_PR_DATA, EXECUTION_END
  );
endinterface
`default_nettype wire

// File: rtl/dispatcher_multi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : one-hot round-robin grant with a rotating priority pointer
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx_w;
  logic             found_w;
  int               dist_w, best_w;

  // Pick the requester with the smallest rotational distance from the pointer.
  always_comb begin
    gidx_w = '0;
    dist_w = 0;
    best_w = N;
    for (int i = 0; i < N; i++) begin
      dist_w = (i + N - int'(ptr_q)) % N;
      if (req_i[i] && (dist_w < best_w)) begin
        best_w = dist_w;
        gidx_w = PTR_W'(i);
      end
    end
    found_w = (best_w < N);
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = found_w && (gidx_w == PTR_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found_w) begin
      ptr_d = (gidx_w == PTR_W'(N - 1)) ? '0 : gidx_w + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/dispatcher_multi.sv
`default_nettype none
// ============================================================================
// dispatcher_multi : NUM_IN->PR/NUM_MU token router; DISPATCHER_STATS_EN adds counters
// Revision         : 1.0
// ============================================================================
module dispatcher_multi
  import ddcpu_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int NUM_MU = 2
) (
  input  logic CLK,
  input  logic RST,
  dispatcher_multi_if.slave bus
`ifdef DISPATCHER_STATS_EN
  ,
  output logic [31:0] STAT_PR_COUNT,
  output logic [31:0] STAT_WR_COUNT,
  output logic [31:0] STAT_NOP_COUNT
`endif
);
  localparam int W    = WORKER_RESULT_WIDTH;
  localparam int MU_W = (NUM_MU > 1) ? $clog2(NUM_MU) : 1;

  function automatic logic [MU_W-1:0] mu_index(input worker_result_t w);
    logic [15:0] h;
    h = wr_dest_addr(w) ^ wr_color(w);
    if (NUM_MU == 1) return '0;
    return h[MU_W-1:0];
  endfunction

  worker_result_t   lane_word_w [NUM_IN];
  target_e          lane_tgt_w  [NUM_IN];
  logic [MU_W-1:0]  lane_mu_w   [NUM_IN];

  logic [NUM_IN-1:0] elig_w, grant_w;
  logic              xfer_w;
  logic              pr_free_w;
  logic [NUM_MU-1:0] mu_free_w;

  worker_result_t    sel_word_w;
  target_e           sel_tgt_w;
  logic [MU_W-1:0]   sel_mu_w;

  logic              pr_valid_q, pr_valid_d;
  packet_request_t   pr_data_q,  pr_data_d;
  logic [NUM_MU-1:0] mu_valid_q, mu_valid_d;
  worker_result_t    mu_data_q [NUM_MU];
  worker_result_t    mu_data_d [NUM_MU];
  logic              end_q, end_d;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign lane_word_w[i] = bus.RECEIVE_WR_DATA[i*W +: W];
    assign lane_tgt_w[i]  = wr_target(lane_word_w[i]);
    assign lane_mu_w[i]   = mu_index(lane_word_w[i]);
  end

  // A slot accepts a new token if empty or being emptied this same cycle.
  assign pr_free_w = !pr_valid_q || bus.SEND_PR_READY;
  assign mu_free_w = ~mu_valid_q | bus.SEND_WR_READY;

  always_comb begin
    elig_w = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.RECEIVE_WR_VALID[i] && !RST) begin
        case (lane_tgt_w[i])
          TGT_PR:  elig_w[i] = pr_free_w;
          TGT_MU:  elig_w[i] = mu_free_w[lane_mu_w[i]];
          default: elig_w[i] = 1'b1;
        endcase
      end
    end
  end

  assign xfer_w = |elig_w;

  rr_arbiter #(.N(NUM_IN)) u_arb (
    .clk       (CLK),
    .rst       (RST),
    .req_i     (elig_w),
    .advance_i (xfer_w),
    .grant_o   (grant_w)
  );

  assign bus.RECEIVE_WR_READY = grant_w;

  always_comb begin
    sel_word_w = '0;
    sel_tgt_w  = TGT_NONE;
    sel_mu_w   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_w[i]) begin
        sel_word_w = lane_word_w[i];
        sel_tgt_w  = lane_tgt_w[i];
        sel_mu_w   = lane_mu_w[i];
      end
    end
  end

  // Drain first, then a load overrides so load+drain keeps the slot full.
  always_comb begin
    pr_valid_d = pr_valid_q;
    pr_data_d  = pr_data_q;
    if (pr_valid_q && bus.SEND_PR_READY) pr_valid_d = 1'b0;
    if (xfer_w && (sel_tgt_w == TGT_PR)) begin
      pr_valid_d = 1'b1;
      pr_data_d  = make_packet_request(wr_option(sel_word_w), wr_dest_addr(sel_word_w),
                                       wr_color(sel_word_w), wr_data(sel_word_w), 32'h0);
    end
    for (int k = 0; k < NUM_MU; k++) begin
      mu_valid_d[k] = mu_valid_q[k];
      mu_data_d[k]  = mu_data_q[k];
      if (mu_valid_q[k] && bus.SEND_WR_READY[k]) mu_valid_d[k] = 1'b0;
      if (xfer_w && (sel_tgt_w == TGT_MU) && (sel_mu_w == MU_W'(k))) begin
        mu_valid_d[k] = 1'b1;
        mu_data_d[k]  = sel_word_w;
      end
    end
    end_d = end_q || (xfer_w && (wr_option(sel_word_w) == OPT_END));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pr_valid_q <= 1'b0;
      pr_data_q  <= '0;
      mu_valid_q <= '0;
      end_q      <= 1'b0;
      for (int k = 0; k < NUM_MU; k++) mu_data_q[k] <= '0;
    end else begin
      pr_valid_q <= pr_valid_d;
      pr_data_q  <= pr_data_d;
      mu_valid_q <= mu_valid_d;
      end_q      <= end_d;
      for (int k = 0; k < NUM_MU; k++) mu_data_q[k] <= mu_data_d[k];
    end
  end

  assign bus.SEND_PR_VALID = pr_valid_q;
  assign bus.SEND_PR_DATA  = pr_data_q;
  assign bus.SEND_WR_VALID = mu_valid_q;
  assign bus.EXECUTION_END = end_q;

  for (genvar k = 0; k < NUM_MU; k++) begin : g_mu
    assign bus.SEND_WR_DATA[k*W +: W] = mu_data_q[k];
  end

`ifdef DISPATCHER_STATS_EN
  logic [31:0] stat_pr_q, stat_pr_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_nop_q, stat_nop_d;

  // END and unknown codes are counted with NOP.
  assign stat_pr_d  = sat_inc(stat_pr_q,  xfer_w && (sel_tgt_w == TGT_PR));
  assign stat_wr_d  = sat_inc(stat_wr_q,  xfer_w && (sel_tgt_w == TGT_MU));
  assign stat_nop_d = sat_inc(stat_nop_q, xfer_w && (sel_tgt_w == TGT_NONE));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_pr_q  <= '0;
      stat_wr_q  <= '0;
      stat_nop_q <= '0;
    end else begin
      stat_pr_q  <= stat_pr_d;
      stat_wr_q  <= stat_wr_d;
      stat_nop_q <= stat_nop_d;
    end
  end

  assign STAT_PR_COUNT  = stat_pr_q;
  assign STAT_WR_COUNT  = stat_wr_q;
  assign STAT_NOP_COUNT = stat_nop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatcher_multi.sv
`default_nettype none
// ============================================================================
// tb_dispatcher_multi : directed and randomized checks against a dispatch model
// Revision            : 1.0
// ============================================================================
module tb_dispatcher_multi;
  localparam int NIN = 2;
  localparam int NMU = 2;
  localparam int W   = 67;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dispatcher_multi_if #(.NUM_IN(NIN), .NUM_MU(NMU)) bus ();

`ifdef DISPATCHER_STATS_EN
  logic [31:0] stat_pr, stat_wr, stat_nop;
`endif

  dispatcher_multi #(.NUM_IN(NIN), .NUM_MU(NMU)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef DISPATCHER_STATS_EN
    ,
    .STAT_PR_COUNT  (stat_pr),
    .STAT_WR_COUNT  (stat_wr),
    .STAT_NOP_COUNT (stat_nop)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: slot contents, priority pointer, sticky end, class counts.
  bit           m_pr_v;
  logic [98:0]  m_pr_d;
  bit           m_mu_v [NMU];
  logic [W-1:0] m_mu_d [NMU];
  int           m_ptr;
  bit           m_end;
  int           m_cnt_pr, m_cnt_wr, m_cnt_nop;

  task automatic model_reset();
    m_pr_v = 0; m_pr_d = '0; m_ptr = 0; m_end = 0;
    m_cnt_pr = 0; m_cnt_wr = 0; m_cnt_nop = 0;
    for (int k = 0; k < NMU; k++) begin m_mu_v[k] = 0; m_mu_d[k] = '0; end
  endtask

  // 0: no slot, 1: packet-request slot, 2: MU slot k
  function automatic int m_target(input logic [W-1:0] w, output int k);
    logic [15:0] h;
    h = w[63:48] ^ w[47:32];
    k = int'(h) % NMU;
    case (w[66:64])
      3'd2, 3'd3: return 1;
      3'd4, 3'd5: return 2;
      default:    return 0;
    endcase
  endfunction

  function automatic int m_grant();
    int l, t, k;
    logic [W-1:0] w;
    if (RST) return -1;
    for (int off = 0; off < NIN; off++) begin
      l = (m_ptr + off) % NIN;
      if (bus.RECEIVE_WR_VALID[l]) begin
        w = bus.RECEIVE_WR_DATA[l*W +: W];
        t = m_target(w, k);
        if (t == 0) return l;
        if (t == 1 && (!m_pr_v || bus.SEND_PR_READY)) return l;
        if (t == 2 && (!m_mu_v[k] || bus.SEND_WR_READY[k])) return l;
      end
    end
    return -1;
  endfunction

  task automatic model_advance();
    int g, t, k;
    logic [W-1:0] w;
    if (RST) return;
    g = m_grant();
    if (m_pr_v && bus.SEND_PR_READY) m_pr_v = 0;
    for (int j = 0; j < NMU; j++) if (m_mu_v[j] && bus.SEND_WR_READY[j]) m_mu_v[j] = 0;
    if (g >= 0) begin
      w = bus.RECEIVE_WR_DATA[g*W +: W];
      t = m_target(w, k);
      if (t == 1) begin m_pr_v = 1; m_pr_d = {w, 32'h0}; m_cnt_pr++; end
      else if (t == 2) begin m_mu_v[k] = 1; m_mu_d[k] = w; m_cnt_wr++; end
      else m_cnt_nop++;
      if (w[66:64] == 3'd1) m_end = 1;
      m_ptr = (g + 1) % NIN;
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_lane(input int l, input bit v, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] c, input logic [31:0] d);
    bus.RECEIVE_WR_VALID[l]       = v;
    bus.RECEIVE_WR_DATA[l*W +: W] = {o, a, c, d};
  endtask

  task automatic idle_lanes();
    for (int l = 0; l < NIN; l++) set_lane(l, 1'b0, 3'd0, 16'h0, 16'h0, 32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_lanes();
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.SEND_PR_READY = 1'b1;
    bus.SEND_WR_READY = '1;
    set_lane(0, 1'b1, 3'd2, 16'h1, 16'h2, 32'h3);
    set_lane(1, 1'b1, 3'd4, 16'h4, 16'h5, 32'h6);
    model_reset();
    #1;
    n_total++; if (bus.RECEIVE_WR_READY !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b want=00", bus.RECEIVE_WR_READY); end
    n_total++; if (bus.SEND_PR_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_pr_valid got=%b want=0", bus.SEND_PR_VALID); end
    n_total++; if (bus.SEND_WR_VALID !== 2'b00) begin n_bad++; $display("FAIL reset_wr_valid got=%b want=00", bus.SEND_WR_VALID); end
    n_total++; if (bus.EXECUTION_END !== 1'b0) begin n_bad++; $display("FAIL reset_end got=%b want=0", bus.EXECUTION_END); end
    idle_lanes();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_exec_pr();
    logic [98:0] exp_pr;
    exp_pr = {3'd2, 16'h1111, 16'h2222, 32'h3333_4444, 32'h0};
    set_lane(0, 1'b1, 3'd2, 16'h1111, 16'h2222, 32'h3333_4444);
    #1;
    n_total++; if (bus.RECEIVE_WR_READY !== 2'b01) begin n_bad++; $display("FAIL exec_ready got=%b want=01", bus.RECEIVE_WR_READY); end
    n_total++; if (bus.SEND_PR_VALID !== 1'b0) begin n_bad++; $display("FAIL exec_pr_early got=%b want=0", bus.SEND_PR_VALID); end
    tick();
    set_lane(0, 1'b0, 3'd0, 16'h0, 16'h0, 32'h0);
    #1;
    n_total++; if (bus.SEND_PR_VALID !== 1'b1) begin n_bad++; $display("FAIL exec_pr_valid got=%b want=1", bus.SEND_PR_VALID); end
    n_total++; if (bus.SEND_PR_DATA !== exp_pr) begin n_bad++; $display("FAIL exec_pr_data got=%h want=%h", bus.SEND_PR_DATA, exp_pr); end
    n_total++; if (bus.SEND_WR_VALID !== 2'b00) begin n_bad++; $display("FAIL exec_no_wr got=%b want=00", bus.SEND_WR_VALID); end
    tick();
    n_total++; if (bus.SEND_PR_VALID !== 1'b0) begin n_bad++; $display("FAIL exec_pr_drain got=%b want=0", bus.SEND_PR_VALID); end
  endtask

  task automatic test_mu_hash();
    logic [W-1:0] w1, w2;
    w1 = {3'd4, 16'h9999, 16'haaaa, 32'h0123_4567};
    w2 = {3'd5, 16'hdddd, 16'heeee, 32'h89ab_cdef};
    set_lane(0, 1'b1, 3'd4, 16'h9999, 16'haaaa, 32'h0123_4567);
    tick();
    set_lane(0, 1'b1, 3'd5, 16'hdddd, 16'heeee, 32'h89ab_cdef);
    #1;
    n_total++; if (bus.SEND_WR_VALID !== 2'b10) begin n_bad++; $display("FAIL left_lane got=%b want=10", bus.SEND_WR_VALID); end
    n_total++; if (bus.SEND_WR_DATA[W +: W] !== w1) begin n_bad++; $display("FAIL left_data got=%h want=%h", bus.SEND_WR_DATA[W +: W], w1); end
    n_total++; if (bus.SEND_PR_VALID !== 1'b0) begin n_bad++; $display("FAIL left_no_pr got=%b want=0", bus.SEND_PR_VALID); end
    tick();
    set_lane(0, 1'b0, 3'd0, 16'h0, 16'h0, 32'h0);
    #1;
    n_total++; if (bus.SEND_WR_VALID !== 2'b10) begin n_bad++; $display("FAIL right_lane got=%b want=10", bus.SEND_WR_VALID); end
    n_total++; if (bus.SEND_WR_DATA[W +: W] !== w2) begin n_bad++; $display("FAIL right_data got=%h want=%h", bus.SEND_WR_DATA[W +: W], w2); end
    tick();
  endtask

  task automatic test_round_robin();
    int cnt [NIN];
    logic [1:0] exp_r;
    do_reset();
    bus.SEND_PR_READY = 1'b1;
    cnt[0] = 0; cnt[1] = 0;
    set_lane(0, 1'b1, 3'd2, 16'h0a0a, 16'h0b0b, 32'h1);
    set_lane(1, 1'b1, 3'd2, 16'h0c0c, 16'h0d0d, 32'h2);
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_total++; if (bus.RECEIVE_WR_READY !== exp_r) begin n_bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", c, bus.RECEIVE_WR_READY, exp_r); end
      if (bus.RECEIVE_WR_READY[0] === 1'b1) cnt[0]++;
      if (bus.RECEIVE_WR_READY[1] === 1'b1) cnt[1]++;
      tick();
    end
    idle_lanes();
    n_total++; if (cnt[0] != 5) begin n_bad++; $display("FAIL rr_count0 got=%0d want=5", cnt[0]); end
    n_total++; if (cnt[1] != 5) begin n_bad++; $display("FAIL rr_count1 got=%0d want=5", cnt[1]); end
    tick();
  endtask

  task automatic test_fairness();
    logic [W-1:0] w0, w1;
    w0 = {3'd4, 16'h0001, 16'h0001, 32'haaaa_0000};
    w1 = {3'd4, 16'h0001, 16'h0001, 32'hbbbb_0000};
    do_reset();
    bus.SEND_PR_READY = 1'b1;
    bus.SEND_WR_READY = 2'b10;
    set_lane(0, 1'b1, 3'd4, 16'h0001, 16'h0001, 32'haaaa_0000);
    tick();
    set_lane(0, 1'b1, 3'd4, 16'h0001, 16'h0001, 32'hbbbb_0000);
    set_lane(1, 1'b1, 3'd3, 16'h0005, 16'h0006, 32'h7);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_total++; if (bus.RECEIVE_WR_READY !== 2'b10) begin n_bad++; $display("FAIL fair_blocked[%0d] got=%b want=10", c, bus.RECEIVE_WR_READY); end
      n_total++; if (bus.SEND_WR_DATA[0 +: W] !== w0 || bus.SEND_WR_VALID[0] !== 1'b1) begin
        n_bad++; $display("FAIL fair_hold[%0d] got=%h want=%h", c, bus.SEND_WR_DATA[0 +: W], w0); end
      tick();
    end
    bus.SEND_WR_READY = 2'b11;
    #1;
    n_total++; if (bus.RECEIVE_WR_READY !== 2'b01) begin n_bad++; $display("FAIL fair_release got=%b want=01", bus.RECEIVE_WR_READY); end
    tick();
    idle_lanes();
    #1;
    n_total++; if (bus.SEND_WR_DATA[0 +: W] !== w1 || bus.SEND_WR_VALID[0] !== 1'b1) begin
      n_bad++; $display("FAIL fair_new got=%h want=%h", bus.SEND_WR_DATA[0 +: W], w1); end
    tick();
  endtask

  task automatic test_nop_end();
    do_reset();
    bus.SEND_PR_READY = 1'b1;
    bus.SEND_WR_READY = 2'b11;
    set_lane(0, 1'b1, 3'd0, 16'h1, 16'h2, 32'h3);
    #1;
    n_total++; if (bus.RECEIVE_WR_READY !== 2'b01) begin n_bad++; $display("FAIL nop_ready got=%b want=01", bus.RECEIVE_WR_READY); end
    tick();
    set_lane(0, 1'b1, 3'd1, 16'h1, 16'h2, 32'h3);
    #1;
    n_total++; if ({bus.SEND_PR_VALID, bus.SEND_WR_VALID} !== 3'b000) begin n_bad++; $display("FAIL nop_out got=%b want=000", {bus.SEND_PR_VALID, bus.SEND_WR_VALID}); end
    n_total++; if (bus.EXECUTION_END !== 1'b0) begin n_bad++; $display("FAIL end_early got=%b want=0", bus.EXECUTION_END); end
    tick();
    set_lane(0, 1'b1, 3'd2, 16'h4, 16'h5, 32'h6);
    #1;
    n_total++; if (bus.EXECUTION_END !== 1'b1) begin n_bad++; $display("FAIL end_set got=%b want=1", bus.EXECUTION_END); end
    n_total++; if ({bus.SEND_PR_VALID, bus.SEND_WR_VALID} !== 3'b000) begin n_bad++; $display("FAIL end_out got=%b want=000", {bus.SEND_PR_VALID, bus.SEND_WR_VALID}); end
    tick();
    #1;
    n_total++; if (bus.SEND_PR_VALID !== 1'b1 || bus.EXECUTION_END !== 1'b1) begin
      n_bad++; $display("FAIL post_end_exec got=%b%b want=11", bus.SEND_PR_VALID, bus.EXECUTION_END); end
    #1;
    RST = 1'b1;
    #1;
    n_total++; if (bus.EXECUTION_END !== 1'b0) begin n_bad++; $display("FAIL async_rst_end got=%b want=0", bus.EXECUTION_END); end
    n_total++; if ({bus.SEND_PR_VALID, bus.SEND_WR_VALID, bus.RECEIVE_WR_READY} !== 5'b0) begin
      n_bad++; $display("FAIL async_rst_out got=%b want=00000", {bus.SEND_PR_VALID, bus.SEND_WR_VALID, bus.RECEIVE_WR_READY}); end
    model_reset();
    idle_lanes();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_random();
    int g;
    logic [NIN-1:0] exp_r;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int l = 0; l < NIN; l++)
        set_lane(l, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), $urandom);
      bus.SEND_PR_READY = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NMU; k++) bus.SEND_WR_READY[k] = ($urandom_range(0, 3) != 0);
      #1;
      g = m_grant();
      exp_r = (g < 0) ? '0 : NIN'(1 << g);
      n_total++; if (bus.RECEIVE_WR_READY !== exp_r) begin n_bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, bus.RECEIVE_WR_READY, exp_r); end
      n_total++; if (bus.SEND_PR_VALID !== m_pr_v) begin n_bad++; $display("FAIL rnd_pr_valid[%0d] got=%b want=%b", c, bus.SEND_PR_VALID, m_pr_v); end
      if (m_pr_v) begin
        n_total++; if (bus.SEND_PR_DATA !== m_pr_d) begin n_bad++; $display("FAIL rnd_pr_data[%0d] got=%h want=%h", c, bus.SEND_PR_DATA, m_pr_d); end
      end
      for (int k = 0; k < NMU; k++) begin
        n_total++; if (bus.SEND_WR_VALID[k] !== m_mu_v[k]) begin n_bad++; $display("FAIL rnd_wr_valid%0d[%0d] got=%b want=%b", k, c, bus.SEND_WR_VALID[k], m_mu_v[k]); end
        if (m_mu_v[k]) begin
          n_total++; if (bus.SEND_WR_DATA[k*W +: W] !== m_mu_d[k]) begin
            n_bad++; $display("FAIL rnd_wr_data%0d[%0d] got=%h want=%h", k, c, bus.SEND_WR_DATA[k*W +: W], m_mu_d[k]); end
        end
      end
      n_total++; if (bus.EXECUTION_END !== m_end) begin n_bad++; $display("FAIL rnd_end[%0d] got=%b want=%b", c, bus.EXECUTION_END, m_end); end
      tick();
    end
    idle_lanes();
    tick();
  endtask

`ifdef DISPATCHER_STATS_EN
  task automatic test_stats();
    logic [2:0] opts [6];
    opts[0] = 3'd2; opts[1] = 3'd3; opts[2] = 3'd4; opts[3] = 3'd5; opts[4] = 3'd0; opts[5] = 3'd1;
    do_reset();
    bus.SEND_PR_READY = 1'b1;
    bus.SEND_WR_READY = '1;
    for (int r = 0; r < 10; r++)
      for (int i = 0; i < 6; i++) begin
        set_lane(0, 1'b1, opts[i], 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), $urandom);
        tick();
      end
    idle_lanes();
    #1;
    n_total++; if (stat_pr !== 32'd20) begin n_bad++; $display("FAIL stat_pr got=%0d want=20", stat_pr); end
    n_total++; if (stat_wr !== 32'd20) begin n_bad++; $display("FAIL stat_wr got=%0d want=20", stat_wr); end
    n_total++; if (stat_nop !== 32'd20) begin n_bad++; $display("FAIL stat_nop got=%0d want=20", stat_nop); end
  endtask
`endif

  initial begin
    bus.RECEIVE_WR_VALID = '0;
    bus.RECEIVE_WR_DATA  = '0;
    bus.SEND_PR_READY    = 1'b1;
    bus.SEND_WR_READY    = '1;
    model_reset();
    test_reset();
    test_exec_pr();
    test_mu_hash();
    test_round_robin();
    test_fairness();
    test_nop_end();
    test_random();
`ifdef DISPATCHER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatcher_multi.md
Name: dispatcher_multi

Overview:
- Parametrised successor to the single-channel dispatcher.
- Accepts worker results from NUM_IN worker lanes using round-robin arbitration.
- Routes each token by destination option:
  - EXEC/ONE go to the packet-request port.
  - LEFT/RIGHT go to one of NUM_MU matching-unit lanes, selected by hash.
  - NOP is dropped.
  - END sets a sticky EXECUTION_END.
- Every output is registered through a one-entry slot with valid/ready handshakes.

Parameters:
- NUM_IN, 2, number of worker-result input lanes (1..8).
- NUM_MU, 2, number of matching-unit output lanes (power of two, 1..8).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- RECEIVE_WR_VALID  in  NUM_IN  per-lane valid
- RECEIVE_WR_DATA  in  NUM_IN*WORKER_RESULT_WIDTH  lane i at bits [i*W +: W]
- RECEIVE_WR_READY  out  NUM_IN  per-lane ready
- SEND_WR_VALID  out  NUM_MU  per-MU-lane valid
- SEND_WR_DATA  out  NUM_MU*WORKER_RESULT_WIDTH  forwarded worker result, unmodified
- SEND_WR_READY  in  NUM_MU  per-MU-lane ready
- SEND_PR_VALID  out  1  packet-request valid
- SEND_PR_DATA  out  PACKET_REQUEST_WIDTH  packet request
- SEND_PR_READY  in  1  packet-request ready
- EXECUTION_END  out  1  sticky; END token seen

Behaviour:
- Reset (async, RST=1): all *_VALID=0, all RECEIVE_WR_READY=0, EXECUTION_END=0, arbiter pointer=0, slots emptied. In-flight tokens are discarded.
- Worker result fields, MSB to LSB: option[2:0], dest_addr[15:0], color[15:0], data[31:0].
- Target decode per input lane:
  - EXEC/ONE → PR slot.
  - LEFT/RIGHT → MU slot k = (dest_addr ^ color)[log2(NUM_MU)-1:0]; k = 0 when NUM_MU = 1.
  - NOP/END → no slot; always eligible.
- Eligibility: a lane is eligible when its VALID is high and its target slot is empty or is draining this cycle (slot valid && slot ready).
- Arbitration:
  - At most one input is accepted per cycle.
  - The grant goes to the first eligible lane at or after the pointer, wrapping.
  - RECEIVE_WR_READY is one-hot on the granted lane, or all zero.
  - Ready is a function of VALID: combinational, no combinational ready→valid loop.
  - On a transfer, the pointer becomes grant+1 mod NUM_IN. With no transfer, the pointer holds.
- Slot load: a transfer in cycle N makes the slot valid from cycle N+1 (latency 1).
- Slot hold:
  - The slot holds its data stable while valid && !ready.
  - Load and drain in the same cycle are allowed; the new token replaces the old one, giving 1 token/cycle throughput.
- PR slot data: {option, dest_addr, color, data, 32'h0}.
- MU slot data: the input word, unmodified.
- NOP: accepted and dropped; no output.
- END:
  - EXECUTION_END rises the cycle after the transfer and stays high until RST.
  - Tokens after END are still dispatched normally.
- Unknown option codes (6, 7) are treated as NOP.
- Fairness: a lane that is blocked on a full slot does not stall other lanes whose targets are free.

Optional Feature:
- DISPATCHER_STATS_EN defined: adds outputs STAT_PR_COUNT, STAT_WR_COUNT and STAT_NOP_COUNT, each 32-bit.
  - Each counter increments once per accepted token of its class.
  - END counts toward NOP.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ddcpu_pkg holds:
  - WORKER_RESULT_WIDTH=67 and PACKET_REQUEST_WIDTH=99.
  - DEST_OPTION codes: NOP=0, END=1, EXEC=2, ONE=3, LEFT=4, RIGHT=5.
  - Field-extract functions.
  - make_worker_result / make_packet_request.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: request vector and advance strobe.
  - Output: one-hot grant.
  - Holds the rotating pointer.
  - Reused by future merge blocks.

Test Plan:
- Config NUM_IN=2, NUM_MU=2. Lane0 sends EXEC, addr 16'h1111, color 16'h2222, data 32'h3333_4444, PR ready=1 → SEND_PR_DATA = make_packet_request(EXEC, 1111, 2222, 33334444, 0) one cycle after the transfer.
- LEFT addr 16'h9999, color 16'haaaa (hash bit 1) → appears only on MU lane 1, unmodified. Then RIGHT addr 16'hdddd, color 16'heeee (hash 1) → also on lane 1.
- Both lanes hold valid EXEC tokens continuously, PR ready=1 → grants alternate 0,1,0,1; after 10 transfers each lane has received 5.
- MU lane 0 ready=0 with its slot full. Lane0 sends LEFT targeting MU 0; lane1 sends ONE → lane1 is accepted every cycle while lane0 waits; lane0 is accepted on the cycle MU0 ready returns.
- NOP, then END → no output valid; EXECUTION_END=1 on the cycle after the END transfer. A subsequent EXEC is still dispatched. Asserting RST mid-stream clears EXECUTION_END and all valids asynchronously.
- With DISPATCHER_STATS_EN, 10 rounds of {EXEC, ONE, LEFT, RIGHT, NOP, END} → STAT_PR_COUNT=20, STAT_WR_COUNT=20, STAT_NOP_COUNT=20.
